img_frame_loader: RTL

- Parametrised, double-buffered ingest block between the laptop byte stream and the Viola-Jones `top`.
- Accepts raster-order pixels over a valid/ready handshake and assembles them into one of two frame banks.
- Presents a completed frame to the detector as a flat image bus with a one-cycle `img_rdy` pulse; this replaces testbench-side image loading.
- Adds behaviour the bench path lacks: backpressure, frame abort/restart, and a stall-or-drop mode while the detector is busy.

---
 rtl/img_frame_loader_if.sv | 11 +
 rtl/img_frame_loader.sv | 123 ++++++++++++
 2 files changed

// File: rtl/img_frame_loader_if.sv
// Pixel stream handshake into img_frame_loader: raster-order data with valid/ready.
interface img_frame_loader_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;

  modport master (output pix_in, output pix_valid, input pix_ready);
  modport slave  (input pix_in, input pix_valid, output pix_ready);
endinterface

// File: rtl/img_frame_loader.sv
// Double-buffered frame ingest for the Viola-Jones detector: one bank fills from the
// pixel stream while the other is presented on img_out; banks swap only when the consumer is idle.
module img_frame_loader #(
  parameter int WIDTH          = 40,
  parameter int HEIGHT         = 30,
  parameter int PIX_W          = 8,
  parameter bit DROP_WHEN_BUSY = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset,
  img_frame_loader_if.slave             pix_if,
  input  logic                          frame_start,
  input  logic                          consumer_busy,
  output logic [HEIGHT*WIDTH*PIX_W-1:0] img_out,
  output logic                          img_rdy,
  output logic [15:0]                   wr_row,
  output logic [15:0]                   wr_col,
  output logic [15:0]                   frames_out,
  output logic [15:0]                   frames_dropped
);

  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [15:0]       LAST_COL = 16'(WIDTH - 1);
  localparam logic [15:0]       LAST_ROW = 16'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic {FILL, FULL} state_t;

  state_t            state;
  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  bank0 [NPIX];
  logic [PIX_W-1:0]  bank1 [NPIX];

  logic              xfer;
  logic              last_pix;
  logic [15:0]       cur_row;
  logic [15:0]       cur_col;
  logic [ADDR_W-1:0] cur_addr;

  assign pix_if.pix_ready = (state == FILL) && !reset;
  assign xfer             = pix_if.pix_valid && pix_if.pix_ready;

  // A restart relocates this cycle's pixel to the origin, so a restart can never complete a frame.
  always_comb begin
    cur_row  = wr_row;
    cur_col  = wr_col;
    cur_addr = wr_addr;
    if (frame_start) begin
      cur_row  = '0;
      cur_col  = '0;
      cur_addr = '0;
    end
  end

  assign last_pix = (cur_row == LAST_ROW) && (cur_col == LAST_COL);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= FILL;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b1;
      wr_addr        <= '0;
      wr_row         <= '0;
      wr_col         <= '0;
      img_rdy        <= 1'b0;
      frames_out     <= '0;
      frames_dropped <= '0;
      for (int i = 0; i < NPIX; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else begin
      img_rdy <= 1'b0;
      case (state)
        FILL: begin
          if (xfer) begin
            if (wr_bank) bank1[cur_addr] <= pix_if.pix_in;
            else         bank0[cur_addr] <= pix_if.pix_in;
            if (last_pix) begin
              wr_row  <= '0;
              wr_col  <= '0;
              wr_addr <= '0;
              state   <= FULL;
            end else if (cur_col == LAST_COL) begin
              wr_row  <= cur_row + 16'd1;
              wr_col  <= '0;
              wr_addr <= cur_addr + ADDR_ONE;
            end else begin
              wr_row  <= cur_row;
              wr_col  <= cur_col + 16'd1;
              wr_addr <= cur_addr + ADDR_ONE;
            end
          end else if (frame_start) begin
            wr_row  <= '0;
            wr_col  <= '0;
            wr_addr <= '0;
          end
        end
        FULL: begin
          if (!consumer_busy) begin
            rd_bank    <= wr_bank;
            wr_bank    <= ~wr_bank;
            frames_out <= frames_out + 16'd1;
            img_rdy    <= 1'b1;
            state      <= FILL;
          end else if (DROP_WHEN_BUSY) begin
            if (frames_dropped != 16'hFFFF) frames_dropped <= frames_dropped + 16'd1;
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  for (genvar i = 0; i < NPIX; i++) begin : g_out
    assign img_out[i*PIX_W +: PIX_W] = rd_bank ? bank1[i] : bank0[i];
  end

endmodule
